// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads to a 1-cycle imem, buffers {pc, word}, presents them under valid/ready.
// Latency: issue N -> instr_valid N+2; redirect N -> target valid N+2. IFETCH_MISALIGN_EN enables misaligned-target halt.
// Backpressure: issue stops once buffered + in-flight words would exceed DEPTH; no words are lost.

module instr_fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_rd_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7_5,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misaligned
);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_ent_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic          inflight;
   logic          drop;
   logic          halted;
   logic          redirect_bad;
   logic          issue;
   logic          pop;
   logic          push;
   logic [CW:0]   occ;
   logic [CW-1:0] count;
   logic [31:0]   redirect_addr;
   fetch_ent_t    head;
   fetch_ent_t    push_ent;

`ifdef IFETCH_MISALIGN_EN
   logic halted_q;
   logic misaligned_q;

   assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
   assign halted       = halted_q;
   assign misaligned   = misaligned_q;

   // Any redirect re-evaluates the flag, so an aligned target resumes fetching.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted_q     <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (redirect) begin
         halted_q     <= redirect_bad;
         misaligned_q <= redirect_bad;
      end
   end
`else
   assign redirect_bad = 1'b0;
   assign halted       = 1'b0;
   assign misaligned   = 1'b0;
`endif

   assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;
   assign instr_valid   = (count != '0);
   assign pop           = instr_valid && instr_ready;

   // Occupancy after this cycle's pop, counting the word still returning from imem.
   always_comb begin
      occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
      issue = 1'b0;
      if (!reset) begin
         if (redirect)
            issue = !redirect_bad;
         else
            issue = !halted && (occ < (CW+1)'(DEPTH));
      end
   end

   assign imem_rd_en = issue;
   assign imem_addr  = redirect ? redirect_addr : fetch_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         inflight <= issue;
         drop     <= redirect && inflight && !issue;
         if (issue) begin
            fetch_pc <= imem_addr + 32'd4;
            resp_pc  <= imem_addr;
         end
      end
   end

   // A response landing in the redirect cycle belongs to the old stream.
   assign push          = inflight && !drop && !redirect;
   assign push_ent.pc   = resp_pc;
   assign push_ent.word = imem_rdata;

   instr_fetch_fifo #(
      .W     ($bits(fetch_ent_t)),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop && !redirect),
      .head_dat (head),
      .count    (count)
   );

   assign instr    = head.word;
   assign instr_pc = head.pc;
   assign op       = head.word[6:0];
   assign funct3   = head.word[14:12];
   assign funct7_5 = head.word[30];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized phase, all checked against an
// in-order expected-PC stream model.
module tb_instr_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        misaligned;

   int nchecks = 0;
   int nerr    = 0;
   int acc     = 0;

   logic [31:0] exp_pc;
   logic        mis_m;
   logic        prev_hold;
   logic [31:0] prev_pc;
   logic [31:0] prev_instr;
   logic        s_vld, s_rd, s_mis;
   logic [31:0] s_pc, s_addr;

   instr_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_rd_en  (imem_rd_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .op          (op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .misaligned  (misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] wfun(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h5A3C};
   endfunction

   // Instruction memory: one-cycle read latency, junk on idle cycles.
   always @(posedge clk)
      imem_rdata <= imem_rd_en ? wfun(imem_addr) : $urandom();

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample outputs mid-cycle, update the stream model, then advance.
   task automatic cycle();
      logic [31:0] w;
      @(negedge clk);
      s_vld  = instr_valid;
      s_pc   = instr_pc;
      s_rd   = imem_rd_en;
      s_addr = imem_addr;
      s_mis  = misaligned;
      if (reset) begin
         exp_pc    = RST_PC;
         mis_m     = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("misaligned_flag", {31'b0, misaligned}, {31'b0, mis_m});
         if (mis_m)
            chk("valid_while_halted", {31'b0, instr_valid}, 32'h0);
         if (prev_hold) begin
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_pc", instr_pc, prev_pc);
            chk("hold_instr", instr, prev_instr);
         end
         if (instr_valid && instr_ready) begin
            w = wfun(exp_pc);
            chk("stream_pc", instr_pc, exp_pc);
            chk("stream_instr", instr, w);
            chk("stream_fields", {20'b0, op, funct3, funct7_5, 1'b0},
                {20'b0, w[6:0], w[14:12], w[30], 1'b0});
            exp_pc = exp_pc + 32'd4;
            acc++;
         end
         prev_hold  = instr_valid && !instr_ready && !redirect;
         prev_pc    = instr_pc;
         prev_instr = instr;
         if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_EN
            mis_m = (redirect_pc[1:0] != 2'b00);
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic [31:0] held;

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      exp_pc = RST_PC; mis_m = 1'b0; prev_hold = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
      @(posedge clk);
      #1;
      cycle();
      chk("rst_valid", {31'b0, s_vld}, 32'h0);
      chk("rst_rd_en", {31'b0, s_rd}, 32'h0);
      chk("rst_misaligned", {31'b0, s_mis}, 32'h0);

      // Reset release with decode always ready.
      reset = 1'b0; instr_ready = 1'b1;
      cycle();
      chk("first_rd_en", {31'b0, s_rd}, 32'h1);
      chk("first_addr", s_addr, RST_PC);
      chk("first_valid_n", {31'b0, s_vld}, 32'h0);
      cycle();
      chk("first_valid_n1", {31'b0, s_vld}, 32'h0);
      chk("second_addr", s_addr, RST_PC + 32'd4);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("stream_valid", {31'b0, s_vld}, 32'h1);
         chk("stream_seq_pc", s_pc, RST_PC + 32'(4 * k));
      end

      // Backpressure for 5 cycles.
      instr_ready = 1'b0;
      cycle();
      held = s_pc;
      for (int k = 2; k <= 5; k++) begin
         cycle();
         chk("bp_rd_en", {31'b0, s_rd}, 32'h0);
         chk("bp_held_pc", s_pc, held);
      end

      // Redirect with the buffer full.
      redirect = 1'b1; redirect_pc = 32'h100;
      cycle();
      chk("redir_rd_en", {31'b0, s_rd}, 32'h1);
      chk("redir_addr", s_addr, 32'h100);
      redirect = 1'b0; instr_ready = 1'b1;
      cycle();
      chk("redir_n1_valid", {31'b0, s_vld}, 32'h0);
      cycle();
      chk("redir_n2_valid", {31'b0, s_vld}, 32'h1);
      chk("redir_n2_pc", s_pc, 32'h100);
      cycle();
      cycle();

      // Redirect while a read is in flight and decode is accepting.
      redirect = 1'b1; redirect_pc = 32'h300;
      cycle();
      redirect = 1'b0;
      cycle();
      chk("redir2_n1_valid", {31'b0, s_vld}, 32'h0);
      cycle();
      chk("redir2_n2_pc", s_pc, 32'h300);

      // Fetch address wraps past the top of memory.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect = 1'b0;
      cycle();
      chk("wrap_rd_en", {31'b0, s_rd}, 32'h1);
      chk("wrap_addr", s_addr, 32'h0);
      cycle();
      chk("wrap_pc_hi", s_pc, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_pc_lo", s_pc, 32'h0);

      // Reset with words buffered.
      instr_ready = 1'b0;
      cycle(); cycle(); cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0; instr_ready = 1'b1;
      cycle();
      chk("midrst_valid", {31'b0, s_vld}, 32'h0);
      chk("midrst_addr", s_addr, RST_PC);
      cycle();
      cycle();
      chk("midrst_pc", s_pc, RST_PC);

      // Misaligned redirect target.
      redirect = 1'b1; redirect_pc = 32'h102;
      cycle();
`ifdef IFETCH_MISALIGN_EN
      chk("mis_redir_rd_en", {31'b0, s_rd}, 32'h0);
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("mis_set", {31'b0, s_mis}, 32'h1);
         chk("mis_rd_en", {31'b0, s_rd}, 32'h0);
      end
      redirect = 1'b1; redirect_pc = 32'h200;
      cycle();
      chk("mis_clr_addr", s_addr, 32'h200);
      redirect = 1'b0;
      cycle();
      chk("mis_clr", {31'b0, s_mis}, 32'h0);
      cycle();
      chk("mis_clr_pc", s_pc, 32'h200);
`else
      chk("align_addr", s_addr, 32'h100);
      redirect = 1'b0;
      cycle();
      chk("align_mis", {31'b0, s_mis}, 32'h0);
      cycle();
      chk("align_pc", s_pc, 32'h100);
`endif

      // Randomized phase.
      acc = 0;
      for (int c = 0; c < 400; c++) begin
         instr_ready = ($urandom_range(9) < 7);
         redirect    = ($urandom_range(19) == 0);
         redirect_pc = $urandom() & 32'h0000_0FFC;
`ifdef IFETCH_MISALIGN_EN
         if ($urandom_range(3) == 0)
            redirect_pc[1:0] = 2'($urandom_range(1, 3));
`else
         redirect_pc[1:0] = 2'($urandom_range(3));
`endif
         reset = ($urandom_range(99) == 0);
         cycle();
      end
      reset = 1'b0; redirect = 1'b0;
      chk("random_progress", {31'b0, (acc >= 60)}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule
